// File: rtl/pwm_decoder.sv
// rtl/pwm_decoder.sv - PWM duty-cycle, transition-count and stuck-line decoder
//
// Purpose:
//   Integrates a single-bit PWM stream over a window of 2**MXWINBITS clock
//   cycles. At the end of every window it reports the high-sample count, a
//   quantized duty code, the transition count (saturating at 255) and
//   stuck-high / stuck-low flags, and raises a one-cycle duty_valid strobe.
//   Dropping enable or asserting reset mid-window discards the partial window.
//
// Optional feature macro: PWM_DECODER_SYNC_EN
//   defined   - two-flop ASYNC_REG synchronizer, pwm_in may be asynchronous
//   undefined - single input register, pwm_in must be synchronous to clock
//
// Ports:
//   clock      in   system clock
//   reset_n    in   synchronous reset, active-low
//   pwm_in     in   PWM stream
//   enable     in   measurement enable
//   duty       out  [MXDUTYBITS-1:0] quantized duty of the last window
//   high_cnt   out  [MXWINBITS:0]    high samples in the last window
//   edges      out  [7:0]            transitions in the last window (sat. 255)
//   duty_valid out  single-cycle strobe when results update
//   stuck_high out  last window all high with no transitions
//   stuck_low  out  last window all low with no transitions

module pwm_decoder #(
  parameter int MXWINBITS  = 10,
  parameter int MXDUTYBITS = 4
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  pwm_in,
  input  logic                  enable,
  output logic [MXDUTYBITS-1:0] duty,
  output logic [MXWINBITS:0]    high_cnt,
  output logic [7:0]            edges,
  output logic                  duty_valid,
  output logic                  stuck_high,
  output logic                  stuck_low
);

  typedef enum logic {
    ST_IDLE      = 1'b0,
    ST_INTEGRATE = 1'b1
  } state_t;

  localparam logic [MXWINBITS-1:0] WIN_LAST = '1;
  localparam logic [MXWINBITS-1:0] WIN_ONE  = 1;
  localparam logic [MXWINBITS:0]   WIN_FULL = {1'b1, {MXWINBITS{1'b0}}};

  state_t                r_state;
  state_t                w_state_next;
  logic                  w_s;
  logic                  r_s_prev;
  logic [MXWINBITS-1:0]  r_win_cnt;
  logic [MXWINBITS-1:0]  w_win_cnt_next;
  logic [MXWINBITS:0]    r_acc_high;
  logic [MXWINBITS:0]    w_acc_high_next;
  logic [MXWINBITS:0]    w_final_high;
  logic [7:0]            r_acc_edges;
  logic [7:0]            w_acc_edges_next;
  logic [7:0]            w_final_edges;
  logic                  w_edge;
  logic                  w_window_done;
  logic [MXDUTYBITS-1:0] w_duty;

  // Input sampling
`ifdef PWM_DECODER_SYNC_EN
  (* ASYNC_REG = "TRUE" *) logic r_sync1;
  (* ASYNC_REG = "TRUE" *) logic r_sync2;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= pwm_in;
      r_sync2 <= r_sync1;
    end
  end

  assign w_s = r_sync2;
`else
  logic r_sync1;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_sync1 <= 1'b0;
    end else begin
      r_sync1 <= pwm_in;
    end
  end

  assign w_s = r_sync1;
`endif

  // Next-state and accumulator logic. The "final" values fold in the current
  // cycle's sample so the window-end result includes its last sample.
  always_comb begin
    w_state_next     = r_state;
    w_win_cnt_next   = r_win_cnt;
    w_acc_high_next  = r_acc_high;
    w_acc_edges_next = r_acc_edges;
    w_window_done    = 1'b0;
    w_edge           = w_s ^ r_s_prev;
    w_final_high     = r_acc_high + {{MXWINBITS{1'b0}}, w_s};
    w_final_edges    = (r_acc_edges == 8'hFF) ? 8'hFF : (r_acc_edges + {7'd0, w_edge});

    unique case (r_state)
      ST_IDLE: begin
        w_win_cnt_next   = '0;
        w_acc_high_next  = '0;
        w_acc_edges_next = '0;
        if (enable) begin
          w_state_next = ST_INTEGRATE;
        end
      end
      ST_INTEGRATE: begin
        if (!enable) begin
          // Partial window is thrown away; outputs keep the last result.
          w_state_next     = ST_IDLE;
          w_win_cnt_next   = '0;
          w_acc_high_next  = '0;
          w_acc_edges_next = '0;
        end else if (r_win_cnt == WIN_LAST) begin
          // Back-to-back windows: clear and restart with no idle cycle.
          w_window_done    = 1'b1;
          w_win_cnt_next   = '0;
          w_acc_high_next  = '0;
          w_acc_edges_next = '0;
        end else begin
          w_win_cnt_next   = r_win_cnt + WIN_ONE;
          w_acc_high_next  = w_final_high;
          w_acc_edges_next = w_final_edges;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // A full window of highs carries into the top bit; truncation alone would
  // wrap it to zero, so it saturates instead.
  always_comb begin
    if (w_final_high[MXWINBITS]) begin
      w_duty = '1;
    end else begin
      w_duty = w_final_high[MXWINBITS-1 -: MXDUTYBITS];
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_s_prev    <= 1'b0;
      r_win_cnt   <= '0;
      r_acc_high  <= '0;
      r_acc_edges <= '0;
      duty        <= '0;
      high_cnt    <= '0;
      edges       <= '0;
      duty_valid  <= 1'b0;
      stuck_high  <= 1'b0;
      stuck_low   <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      // Tracked in every state so the first INTEGRATE cycle compares against
      // a real previous sample rather than a stale value.
      r_s_prev    <= w_s;
      r_win_cnt   <= w_win_cnt_next;
      r_acc_high  <= w_acc_high_next;
      r_acc_edges <= w_acc_edges_next;
      duty_valid  <= w_window_done;
      if (w_window_done) begin
        duty       <= w_duty;
        high_cnt   <= w_final_high;
        edges      <= w_final_edges;
        stuck_high <= (w_final_edges == 8'd0) && (w_final_high == WIN_FULL);
        stuck_low  <= (w_final_edges == 8'd0) && (w_final_high == '0);
      end
    end
  end

endmodule
